// File: rtl/dma_ram_rd_responder.sv
// Segmented RAM responder: per-segment byte-enabled write port and fixed-latency read pipeline.
// Optional accepted-read statistics counter enabled by defining DMA_RAM_RD_STAT_EN.
module dma_ram_rd_responder #(
    parameter int unsigned SEG_COUNT      = 2,
    parameter int unsigned SEG_DATA_WIDTH = 64,
    parameter int unsigned SEG_ADDR_WIDTH = 8,
    parameter int unsigned SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int unsigned RAM_SEL_WIDTH  = 2,
    parameter int unsigned PIPELINE       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]    ram_wr_cmd_be,
    input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]  ram_wr_cmd_addr,
    input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]  ram_wr_cmd_data,
    input  logic [SEG_COUNT-1:0]                 ram_wr_cmd_valid,
    output logic [SEG_COUNT-1:0]                 ram_wr_cmd_ready,
    output logic [SEG_COUNT-1:0]                 ram_wr_done,
    input  logic [SEG_COUNT*RAM_SEL_WIDTH-1:0]   ram_rd_cmd_sel,
    input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]  ram_rd_cmd_addr,
    input  logic [SEG_COUNT-1:0]                 ram_rd_cmd_valid,
    output logic [SEG_COUNT-1:0]                 ram_rd_cmd_ready,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]  ram_rd_resp_data,
    output logic [SEG_COUNT-1:0]                 ram_rd_resp_valid,
    input  logic [SEG_COUNT-1:0]                 ram_rd_resp_ready,
    output logic [31:0]                          stat_rd_count
);

    localparam int unsigned DEPTH  = 2 ** SEG_ADDR_WIDTH;
    localparam int unsigned PIPE_W = PIPELINE * SEG_DATA_WIDTH;

    // The select field carries no meaning for a single RAM endpoint.
    logic w_unused_sel;
    assign w_unused_sel = ^ram_rd_cmd_sel;

    assign ram_wr_cmd_ready = {SEG_COUNT{~rst}};

    for (genvar g = 0; g < SEG_COUNT; g++) begin : g_seg
        logic [SEG_ADDR_WIDTH-1:0] w_wr_addr;
        logic [SEG_ADDR_WIDTH-1:0] w_rd_addr;
        logic [SEG_BE_WIDTH-1:0]   w_wr_be;
        logic [SEG_DATA_WIDTH-1:0] w_wr_data;
        logic [SEG_DATA_WIDTH-1:0] w_rd_word;
        logic                      w_wr_en;
        logic                      w_pipe_en;
        logic [PIPELINE-1:0]       r_valid_pipe;
        logic [PIPE_W-1:0]         r_data_pipe;
        logic                      r_wr_done;

        assign w_wr_addr = ram_wr_cmd_addr[g*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
        assign w_rd_addr = ram_rd_cmd_addr[g*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
        assign w_wr_be   = ram_wr_cmd_be[g*SEG_BE_WIDTH +: SEG_BE_WIDTH];
        assign w_wr_data = ram_wr_cmd_data[g*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
        assign w_wr_en   = ram_wr_cmd_valid[g] && ram_wr_cmd_ready[g];
        assign w_pipe_en = !r_valid_pipe[PIPELINE-1] || ram_rd_resp_ready[g];

        // One memory per byte lane so each lane has a single writer; reads see pre-write data.
        for (genvar b = 0; b < SEG_BE_WIDTH; b++) begin : g_lane
            logic [7:0] r_mem_b [DEPTH];

            always_ff @(posedge clk) begin
                if (w_wr_en && w_wr_be[b]) begin
                    r_mem_b[w_wr_addr] <= w_wr_data[b*8 +: 8];
                end
            end

            assign w_rd_word[b*8 +: 8] = r_mem_b[w_rd_addr];
        end

        // Shift-register read pipeline; the whole chain freezes while the head is stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid_pipe <= '0;
                r_data_pipe  <= '0;
                r_wr_done    <= 1'b0;
            end else begin
                r_wr_done <= w_wr_en;
                if (w_pipe_en) begin
                    r_valid_pipe <= (r_valid_pipe << 1) | PIPELINE'(ram_rd_cmd_valid[g]);
                    r_data_pipe  <= (r_data_pipe << SEG_DATA_WIDTH) | PIPE_W'(w_rd_word);
                end
            end
        end

        assign ram_rd_cmd_ready[g]                                  = w_pipe_en;
        assign ram_rd_resp_valid[g]                                 = r_valid_pipe[PIPELINE-1];
        assign ram_rd_resp_data[g*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = r_data_pipe[PIPE_W-1 -: SEG_DATA_WIDTH];
        assign ram_wr_done[g]                                       = r_wr_done;
    end

`ifdef DMA_RAM_RD_STAT_EN
    logic [31:0] r_stat_rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_rd_count <= '0;
        end else begin
            r_stat_rd_count <= r_stat_rd_count + 32'($countones(ram_rd_cmd_valid & ram_rd_cmd_ready));
        end
    end

    assign stat_rd_count = r_stat_rd_count;
`else
    assign stat_rd_count = '0;
`endif

endmodule

// File: tb/tb_dma_ram_rd_responder.sv
// Randomized self-checking bench for dma_ram_rd_responder against a queue-based memory model.
// Honours DMA_RAM_RD_STAT_EN when checking stat_rd_count.
module tb_dma_ram_rd_responder;

    logic         clk;
    logic         rst;
    logic [15:0]  wr_be;
    logic [15:0]  wr_addr;
    logic [127:0] wr_data;
    logic [1:0]   wr_valid;
    logic [1:0]   wr_ready;
    logic [1:0]   wr_done;
    logic [3:0]   rd_sel;
    logic [15:0]  rd_addr;
    logic [1:0]   rd_valid;
    logic [1:0]   rd_ready;
    logic [127:0] resp_data;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [31:0]  stat;

    dma_ram_rd_responder dut (
        .clk               (clk),
        .rst               (rst),
        .ram_wr_cmd_be     (wr_be),
        .ram_wr_cmd_addr   (wr_addr),
        .ram_wr_cmd_data   (wr_data),
        .ram_wr_cmd_valid  (wr_valid),
        .ram_wr_cmd_ready  (wr_ready),
        .ram_wr_done       (wr_done),
        .ram_rd_cmd_sel    (rd_sel),
        .ram_rd_cmd_addr   (rd_addr),
        .ram_rd_cmd_valid  (rd_valid),
        .ram_rd_cmd_ready  (rd_ready),
        .ram_rd_resp_data  (resp_data),
        .ram_rd_resp_valid (resp_valid),
        .ram_rd_resp_ready (resp_ready),
        .stat_rd_count     (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    int          cyc;
    int          n_pop [2];
    logic [63:0] mem_m [2][256];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [1:0]  wr_prev;
    logic [1:0]  hold_v;
    logic [1:0]  acc_last;
    logic [63:0] hold_d [2];
    logic [31:0] stat_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [63:0] qpop(input int s);
        if (s == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int s, input logic [63:0] v);
        if (s == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // One clock of model bookkeeping: inputs were driven at the preceding negedge.
    task automatic step();
        logic [1:0]  wr_acc;
        logic [1:0]  rd_acc;
        logic [63:0] d;
        logic [7:0]  a;
        #1;
        wr_acc = wr_valid & wr_ready;
        rd_acc = rd_valid & rd_ready;
        check("stat_rd_count", 64'(stat), 64'(stat_m));
        for (int s = 0; s < 2; s++) begin
            d = resp_data[s*64 +: 64];
            check("wr_done", 64'(wr_done[s]), 64'(wr_prev[s]));
            check("wr_cmd_ready", 64'(wr_ready[s]), 64'd1);
            if (resp_ready[s]) check("rd_cmd_ready", 64'(rd_ready[s]), 64'd1);
            if (hold_v[s]) begin
                check("stall_valid", 64'(resp_valid[s]), 64'd1);
                check("stall_data", d, hold_d[s]);
            end
            check("resp_orphan", 64'(resp_valid[s] && qsize(s) == 0), 64'd0);
            if (resp_valid[s] && resp_ready[s] && qsize(s) != 0) begin
                check("rd_data", d, qpop(s));
                n_pop[s]++;
            end
            hold_v[s] = resp_valid[s] && !resp_ready[s];
            hold_d[s] = d;
        end
        // Reads sample memory before same-cycle writes land.
        for (int s = 0; s < 2; s++) begin
            if (rd_acc[s]) begin
                a = rd_addr[s*8 +: 8];
                qpush(s, mem_m[s][a]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (wr_acc[s]) begin
                a = wr_addr[s*8 +: 8];
                for (int b = 0; b < 8; b++) begin
                    if (wr_be[s*8 + b]) mem_m[s][a][b*8 +: 8] = wr_data[s*64 + b*8 +: 8];
                end
            end
        end
`ifdef DMA_RAM_RD_STAT_EN
        stat_m = stat_m + 32'($countones(rd_acc));
`endif
        wr_prev  = wr_acc;
        acc_last = rd_acc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr_one(input int s, input logic [7:0] a, input logic [7:0] be, input logic [63:0] d);
        wr_addr[s*8 +: 8]  = a;
        wr_be[s*8 +: 8]    = be;
        wr_data[s*64 +: 64] = d;
        wr_valid[s]        = 1'b1;
        step();
        wr_valid[s]        = 1'b0;
    endtask

    task automatic rd_one(input int s, input logic [7:0] a, input logic [63:0] exp, input string tag);
        int c0;
        resp_ready[s]     = 1'b1;
        rd_addr[s*8 +: 8] = a;
        rd_valid[s]       = 1'b1;
        c0 = cyc;
        step();
        rd_valid = '0;
        wr_valid = '0;
        for (int i = 0; i < 8 && !resp_valid[s]; i++) step();
        check({tag, "_valid"}, 64'(resp_valid[s]), 64'd1);
        check({tag, "_latency"}, 64'(cyc - c0), 64'd2);
        check(tag, resp_data[s*64 +: 64], exp);
        step();
    endtask

    initial begin
        int          idx;
        int          p0;
        logic [31:0] s0;
        logic [31:0] stat_exp;
        n_chk = 0; n_pass = 0; cyc = 0;
        n_pop[0] = 0; n_pop[1] = 0;
        wr_prev = '0; hold_v = '0; acc_last = '0; stat_m = '0;
        hold_d[0] = '0; hold_d[1] = '0;
        rst = 1'b1;
        wr_be = '0; wr_addr = '0; wr_data = '0; wr_valid = '0;
        rd_sel = '0; rd_addr = '0; rd_valid = '0; resp_ready = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_wr_done", 64'(wr_done), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data0", resp_data[63:0], 64'd0);
        check("rst_resp_data1", resp_data[127:64], 64'd0);
        check("rst_stat", 64'(stat), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fill both segments so every model entry is known.
        wr_be = '1;
        for (int a = 0; a < 256; a++) begin
            wr_addr  = {8'(a), 8'(a)};
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            wr_valid = 2'b11;
            step();
        end
        wr_valid = '0;

        wr_one(0, 8'h10, 8'hFF, 64'h1122334455667788);
        rd_one(0, 8'h10, 64'h1122334455667788, "latency_rd");

        wr_one(1, 8'h05, 8'hFF, 64'h0);
        wr_one(1, 8'h05, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
        rd_one(1, 8'h05, 64'h00000000FFFFFFFF, "byte_en");
        wr_one(1, 8'h05, 8'h00, 64'hDEADBEEFDEADBEEF);
        rd_one(1, 8'h05, 64'h00000000FFFFFFFF, "zero_be");

        wr_one(0, 8'h20, 8'hFF, 64'hA);
        wr_addr[7:0]  = 8'h20;
        wr_be[7:0]    = 8'hFF;
        wr_data[63:0] = 64'hB;
        wr_valid[0]   = 1'b1;
        rd_one(0, 8'h20, 64'hA, "collide_old");
        rd_one(0, 8'h20, 64'hB, "collide_new");

        // Backpressure: two-deep pipe fills, then the head must hold.
        resp_ready[0] = 1'b0;
        rd_valid[0]   = 1'b1;
        idx = 0;
        p0  = n_pop[0];
        for (int i = 0; i < 6; i++) begin
            rd_addr[7:0] = 8'(idx);
            step();
            if (acc_last[0]) idx++;
        end
        check("bp_accepts", 64'(idx), 64'd2);
        check("bp_cmd_ready", 64'(rd_ready[0]), 64'd0);
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 20 && (idx < 4 || qsize(0) != 0); i++) begin
            if (idx >= 4) rd_valid[0] = 1'b0;
            rd_addr[7:0] = 8'(idx);
            step();
            if (acc_last[0]) idx++;
        end
        rd_valid[0] = 1'b0;
        step();
        check("bp_total_accepts", 64'(idx), 64'd4);
        check("bp_responses", 64'(n_pop[0] - p0), 64'd4);
        check("bp_queue_empty", 64'(qsize(0)), 64'd0);

        resp_ready = 2'b11;
        rd_valid   = 2'b11;
        rd_addr    = 16'h0302;
        s0 = stat;
        repeat (3) step();
        rd_valid = '0;
`ifdef DMA_RAM_RD_STAT_EN
        stat_exp = 32'd6;
`else
        stat_exp = 32'd0;
`endif
        check("stat_delta", 64'(stat - s0), 64'(stat_exp));
        repeat (4) step();

        // Reset with two reads in flight: they must vanish, memory must survive.
        rd_addr[7:0] = 8'h10;
        rd_valid[0]  = 1'b1;
        step();
        step();
        rd_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_wr_ready", 64'(wr_ready), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_stat", 64'(stat), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        hold_v = '0; wr_prev = '0; stat_m = '0;
        repeat (5) step();
        rd_one(0, 8'h10, 64'h1122334455667788, "mem_kept");

        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < 2; s++) begin
                rd_valid[s]         = ($urandom_range(0, 99) < 70);
                rd_addr[s*8 +: 8]   = 8'($urandom_range(0, 15));
                resp_ready[s]       = ($urandom_range(0, 99) < 65);
                wr_valid[s]         = ($urandom_range(0, 99) < 30);
                wr_addr[s*8 +: 8]   = 8'($urandom_range(0, 15));
                wr_be[s*8 +: 8]     = 8'($urandom);
                wr_data[s*64 +: 64] = {$urandom, $urandom};
            end
            rd_sel = 4'($urandom);
            step();
        end
        rd_valid   = '0;
        wr_valid   = '0;
        resp_ready = 2'b11;
        repeat (8) step();
        check("drain_q0", 64'(qsize(0)), 64'd0);
        check("drain_q1", 64'(qsize(1)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
